// File: rtl/mtree_feeder.sv
// mtree_feeder: streaming front end for the max comparison tree.
// Collects NUM_INPUTS elements (or fewer, closed early by in_last) into one
// packed vector, pads unfilled slots with PAD_VALUE and hands the vector to
// the tree's input register stage over a valid/ready handshake.
// Build option: define MTREE_FEEDER_DBUF_EN for two ping-pong banks, which
// sustain one beat per cycle; the default build uses a single FILL/HOLD bank.
module mtree_feeder #(
    parameter int                  IN_WIDTH   = 32,
    parameter int                  NUM_INPUTS = 8,
    parameter logic [IN_WIDTH-1:0] PAD_VALUE  = '0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [IN_WIDTH-1:0]                  in_data,
    input  logic                                 in_valid,
    input  logic                                 in_last,
    output logic                                 in_ready,
    output logic [NUM_INPUTS-1:0][IN_WIDTH-1:0]  out_data,
    output logic [$clog2(NUM_INPUTS):0]          out_count,
    output logic                                 out_valid,
    input  logic                                 out_ready
);

    localparam int IDX_W = $clog2(NUM_INPUTS);
    localparam int CNT_W = IDX_W + 1;

    typedef logic [NUM_INPUTS-1:0][IN_WIDTH-1:0] vec_t;

    // Fill position within the current frame (shared by both bank schemes)
    logic [IDX_W-1:0] idx_q;
    // Contents of the bank being filled, and its value after this beat
    vec_t             fill_cur;
    vec_t             fill_d;
    logic             frame_close;
    logic [CNT_W-1:0] count_d;

    assign frame_close = in_last || (idx_q == IDX_W'(NUM_INPUTS - 1));
    assign count_d     = {1'b0, idx_q} + CNT_W'(1);

    // Per-slot next value: the current slot takes the beat, and on a frame
    // close every slot past it is overwritten with the pad value so stale
    // data from an earlier frame never reaches the tree.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_slot
            assign fill_d[gi] = (gi == int'(idx_q))                 ? in_data   :
                                (frame_close && (gi > int'(idx_q))) ? PAD_VALUE :
                                                                      fill_cur[gi];
        end
    endgenerate

`ifdef MTREE_FEEDER_DBUF_EN

    // Two banks: one fills while the other waits on the output.
    vec_t             bank_q [2];
    logic [CNT_W-1:0] cnt_q  [2];
    logic [1:0]       full_q;
    logic             wr_sel_q;
    logic             rd_sel_q;
    logic             beat_acc;
    logic             out_fire;

    assign fill_cur  = bank_q[wr_sel_q];
    assign in_ready  = !full_q[wr_sel_q];
    assign out_valid = full_q[rd_sel_q];
    assign out_data  = bank_q[rd_sel_q];
    assign out_count = cnt_q[rd_sel_q];
    assign beat_acc  = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Fill the write bank, close it into the output queue, retire the read
    // bank on handshake. A bank being written is never full and the read
    // bank is full whenever it fires, so both updates touch distinct banks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                bank_q[b] <= {NUM_INPUTS{PAD_VALUE}};
                cnt_q[b]  <= '0;
            end
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            if (beat_acc) begin
                bank_q[wr_sel_q] <= fill_d;
                if (frame_close) begin
                    cnt_q[wr_sel_q]  <= count_d;
                    full_q[wr_sel_q] <= 1'b1;
                    wr_sel_q         <= ~wr_sel_q;
                    idx_q            <= '0;
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
            if (out_fire) begin
                full_q[rd_sel_q] <= 1'b0;
                rd_sel_q         <= ~rd_sel_q;
            end
        end
    end

`else

    typedef enum logic {S_FILL, S_HOLD} state_t;

    state_t           state_q;
    vec_t             data_q;
    logic [CNT_W-1:0] count_q;
    logic             in_ready_q;
    logic             out_valid_q;

    assign fill_cur  = data_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign out_count = count_q;

    // FILL/HOLD controller with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FILL;
            data_q      <= {NUM_INPUTS{PAD_VALUE}};
            count_q     <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (in_valid) begin
                        data_q <= fill_d;
                        if (frame_close) begin
                            count_q     <= count_d;
                            idx_q       <= '0;
                            state_q     <= S_HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state_q     <= S_FILL;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_FILL;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_mtree_feeder.sv
// tb_mtree_feeder: scoreboard bench for mtree_feeder. The driver feeds
// directed and random beats and builds expected vectors from frame rules;
// an independent monitor pops and compares on every output handshake and
// checks that held vectors stay stable.
module tb_mtree_feeder;

    localparam int W     = 32;
    localparam int N     = 8;
    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [W-1:0] PAD = '0;

`ifdef MTREE_FEEDER_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    typedef logic [N-1:0][W-1:0] vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [W-1:0]     in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             in_ready;
    vec_t             out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_valid;
    logic             out_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int vectors_out = 0;
    int vectors_exp = 0;

    vec_t             exp_q[$];
    int               exp_cnt_q[$];
    logic [W-1:0]     part[$];

    mtree_feeder #(.IN_WIDTH(W), .NUM_INPUTS(N), .PAD_VALUE(PAD)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: frame assembly from accepted beats
    task automatic model_accept(input logic [W-1:0] d, input logic last);
        vec_t v;
        part.push_back(d);
        if (last || part.size() == N) begin
            for (int k = 0; k < N; k++) v[k] = (k < part.size()) ? part[k] : PAD;
            exp_q.push_back(v);
            exp_cnt_q.push_back(part.size());
            vectors_exp++;
            $display("expect vector #%0d count=%0d", vectors_exp, part.size());
            part.delete();
        end
    endtask

    // Present one beat until accepted (bounded)
    task automatic send_beat(input logic [W-1:0] d, input logic last);
        bit done = 0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = d; in_last = last;
            if (in_ready) begin
                model_accept(d, last);
                done = 1;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_beat_timeout: actual=stalled required=accepted");
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk); t++;
        end
        @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Monitor: compare on handshake, and check stability while held
    bit               held = 0;
    vec_t             held_data;
    logic [CNT_W-1:0] held_cnt;
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 0;
        end else begin
            if (held) begin
                checks++;
                if (!(out_valid === 1'b1 && out_data === held_data && out_count === held_cnt)) begin
                    errors++;
                    $display("FAIL hold_stable: actual valid=%0b count=%0d required valid=1 count=%0d",
                             out_valid, out_count, held_cnt);
                end
            end
            if (out_valid && out_ready) begin
                vectors_out++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_vector: actual count=%0d required=none", out_count);
                end else begin
                    vec_t ev;
                    int   ec;
                    ev = exp_q.pop_front();
                    ec = exp_cnt_q.pop_front();
                    if (out_data !== ev || out_count !== CNT_W'(ec)) begin
                        errors++;
                        $display("FAIL vector: actual data=%h count=%0d required data=%h count=%0d",
                                 out_data, out_count, ev, ec);
                    end else begin
                        $display("vector #%0d ok count=%0d", vectors_out, out_count);
                    end
                end
            end
            held      = out_valid && !out_ready;
            held_data = out_data;
            held_cnt  = out_count;
        end
    end

    initial begin
        int acc;
        int lows;
        int base;
        vec_t padv;
        for (int k = 0; k < N; k++) padv[k] = PAD;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_count", out_count, 0);
        check("reset_out_data", (out_data === padv), 1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);

        // Full frame 1..8, latency and single-cycle valid
        out_ready = 1'b1;
        for (int i = 1; i <= N; i++) send_beat(W'(i), 1'b0);
        idle();
        @(negedge clk);
        check("latency_valid_rise", out_valid, 1);
        @(negedge clk);
        check("valid_one_cycle", out_valid, 0);

        // Short frame 5,9,3
        send_beat(W'(5), 1'b0);
        send_beat(W'(9), 1'b0);
        send_beat(W'(3), 1'b1);
        idle();
        drain();

        // Held vector for 10 cycles
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) send_beat($urandom, 1'b0);
        idle();
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            logic [W-1:0] d;
            @(posedge clk); #1;
            d = $urandom;
            in_valid = 1'b1; in_data = d; in_last = 1'b0;
            if (in_ready) begin
                model_accept(d, 1'b0);
                acc++;
            end
        end
        check("hold_beats_accepted", acc, DBUF ? N : 0);
        check("hold_in_ready_end", in_ready, 0);
        idle();
        out_ready = 1'b1;
        drain();

        // Continuous 32-beat stream
        base = vectors_out;
        acc = 0; lows = 0;
        for (int c = 0; c < 200 && acc < 32; c++) begin
            logic [W-1:0] d;
            @(posedge clk); #1;
            d = $urandom;
            in_valid = 1'b1; in_data = d; in_last = 1'b0;
            if (in_ready) begin
                model_accept(d, 1'b0);
                acc++;
            end else begin
                lows++;
            end
        end
        idle();
        check("stream_in_ready_after", in_ready, DBUF ? 1 : 0);
        check("stream_ready_lows", lows, DBUF ? 0 : 3);
        drain();
        check("stream_vectors", vectors_out - base, 4);

        // Reset mid-frame
        base = vectors_out;
        for (int i = 0; i < 4; i++) send_beat($urandom, 1'b0);
        idle();
        rst_n = 1'b0;
        part.delete();
        @(negedge clk);
        check("midreset_out_valid", out_valid, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < N; i++) send_beat(W'(100 + i), 1'b0);
        idle();
        drain();
        check("midreset_vectors", vectors_out - base, 1);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            logic [W-1:0] d;
            logic         v, l;
            @(posedge clk); #1;
            d = $urandom;
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid = v; in_data = d; in_last = l;
            if (v && in_ready) model_accept(d, l);
        end
        idle();
        out_ready = 1'b1;
        drain();
        check("total_vectors", vectors_out, vectors_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
